// File: rtl/rtlola_trace_pkg.sv
// ---------------------------------------------------------------------------
// rtlola_trace_pkg
//   Shared types for the RTLola trace player: default widths of the event
//   value and the idle-cycle count, the player FSM state encoding and the
//   packed record stored in the record FIFO.
//   No ports (package).
// ---------------------------------------------------------------------------
package rtlola_trace_pkg;

    // Default width of the signed event value (matches monitor input_0)
    localparam int DATA_W_DEF  = 64;
    // Default width of the per-record idle-cycle count
    localparam int DELTA_W_DEF = 32;

    // Player FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        GAP  = 2'd3
    } player_state_t;

    // One input-event record: idle cycles before the pulse, then the value
    typedef struct packed {
        logic        [DELTA_W_DEF-1:0] delta;
        logic signed [DATA_W_DEF-1:0]  value;
    } trace_rec_t;

endpackage

// File: rtl/rtlola_trace_fifo.sv
// ---------------------------------------------------------------------------
// rtlola_trace_fifo
//   Synchronous first-word fall-through FIFO of trace_rec_t records.
//   The head record is presented on rd_data whenever empty is low.
//   A push while full is dropped, even when a pop happens in the same cycle.
//   An asynchronous reset flushes the FIFO (pointers and occupancy).
// Ports
//   clk      in   1                 clock, posedge
//   rst      in   1                 asynchronous active-high reset
//   push     in   1                 write wr_data (ignored when full)
//   wr_data  in   trace_rec_t       record to write
//   pop      in   1                 drop the head record (ignored when empty)
//   rd_data  out  trace_rec_t       head record (valid while !empty)
//   full     out  1                 occupancy == DEPTH
//   empty    out  1                 occupancy == 0
//   fill     out  $clog2(DEPTH)+1   occupancy
// ---------------------------------------------------------------------------
module rtlola_trace_fifo
    import rtlola_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  trace_rec_t               wr_data,
    input  logic                     pop,
    output trace_rec_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign fill    = count;

endmodule

// File: rtl/rtlola_trace_player.sv
// ---------------------------------------------------------------------------
// rtlola_trace_player
//   Replays (delta, value) input-event records as timed one-cycle pulses on
//   input_0/new_input_0 for the RTLola monitor. Records are buffered in a
//   FIFO; a record popped in cycle t pulses in cycle t+1+delta, and there is
//   always at least one low cycle between two pulses.
//   The FSM and counter advance only while en=1; pushes ignore en.
//   Optional feature (macro RTLOLA_TRACE_TIMESTAMP_EN): a free-running 64-bit
//   cycle counter and the ev_time output holding the counter value of the
//   most recent pulse cycle.
// Ports
//   clk          in   1                 clock, posedge
//   rst          in   1                 asynchronous active-high reset
//   en           in   1                 global enable (same as monitor en)
//   rec_valid    in   1                 upstream record valid
//   rec_ready    out  1                 FIFO can accept a record
//   rec_delta    in   DELTA_W           idle cycles before the pulse
//   rec_value    in   DATA_W            signed event value
//   input_0      out  DATA_W            pulse value, 0 outside the pulse
//   new_input_0  out  1                 one-cycle event strobe
//   busy         out  1                 FSM not IDLE or FIFO non-empty
//   fill         out  $clog2(DEPTH)+1   FIFO occupancy
//   ev_time      out  64                (timestamp build only) pulse cycle
// ---------------------------------------------------------------------------
module rtlola_trace_player
    import rtlola_trace_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      rec_valid,
    output logic                      rec_ready,
    input  logic [DELTA_W-1:0]        rec_delta,
    input  logic signed [DATA_W-1:0]  rec_value,
    output logic signed [DATA_W-1:0]  input_0,
    output logic                      new_input_0,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fill
`ifdef RTLOLA_TRACE_TIMESTAMP_EN
    ,
    output logic [63:0]               ev_time
`endif
);

    player_state_t              state;
    player_state_t              state_next;
    logic [DELTA_W-1:0]         cnt;
    logic [DELTA_W-1:0]         cnt_next;
    logic signed [DATA_W-1:0]   val_q;
    logic signed [DATA_W-1:0]   val_next;

    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    trace_rec_t                 wr_rec;
    trace_rec_t                 rd_rec;
    logic [DELTA_W-1:0]         head_delta;
    logic signed [DATA_W-1:0]   head_value;

    // The record struct fixes the stored widths; the casts keep the port
    // widths and the storage widths decoupled.
    always_comb begin
        wr_rec       = '0;
        wr_rec.delta = DELTA_W_DEF'(rec_delta);
        wr_rec.value = DATA_W_DEF'(rec_value);
    end

    assign head_delta = DELTA_W'(rd_rec.delta);
    assign head_value = DATA_W'(rd_rec.value);

    // rec_ready stays low while reset is held so nothing is offered to a
    // FIFO that is being flushed.
    assign rec_ready = !fifo_full && !rst;
    assign push      = rec_valid && rec_ready;

    rtlola_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_rec),
        .pop     (pop),
        .rd_data (rd_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (fill)
    );

    // State register: FSM state, idle-cycle counter and the value of the
    // record currently being played.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            val_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            val_q <= val_next;
        end
    end

    // Next-state logic. Nothing moves while en is low, which holds EMIT until
    // the pulse can actually be seen by the monitor. WAIT is entered only with
    // a non-zero count and leaves at 1, so the counter never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        val_next   = val_q;
        pop        = 1'b0;
        if (en) begin
            case (state)
                IDLE, GAP: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        cnt_next = head_delta;
                        val_next = head_value;
                        if (head_delta == '0) begin
                            state_next = EMIT;
                        end else begin
                            state_next = WAIT;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                WAIT: begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == DELTA_W'(1)) begin
                        state_next = EMIT;
                    end
                end
                EMIT: begin
                    state_next = GAP;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output logic: the strobe and value are decoded from registered state,
    // and gated by en so a held EMIT never shows a pulse the monitor would
    // ignore.
    always_comb begin
        new_input_0 = 1'b0;
        input_0     = '0;
        if (state == EMIT && en) begin
            new_input_0 = 1'b1;
            input_0     = val_q;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

`ifdef RTLOLA_TRACE_TIMESTAMP_EN
    logic [63:0] cyc;

    // Free-running cycle counter; ev_time latches it on every visible pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc     <= '0;
            ev_time <= '0;
        end else begin
            cyc <= cyc + 64'd1;
            if (new_input_0) begin
                ev_time <= cyc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtlola_trace_player.sv
// ---------------------------------------------------------------------------
// tb_rtlola_trace_player
//   Directed bench for rtlola_trace_player. Inputs change and outputs are
//   sampled just after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rtlola_trace_player;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               rec_valid;
    logic               rec_ready;
    logic [31:0]        rec_delta;
    logic signed [63:0] rec_value;
    logic signed [63:0] input_0;
    logic               new_input_0;
    logic               busy;
    logic [4:0]         fill;
`ifdef RTLOLA_TRACE_TIMESTAMP_EN
    logic [63:0]        ev_time;
`endif

    int                 checks = 0;
    int                 failures = 0;
    logic [63:0]        tb_cyc;
    logic [63:0]        exp_time;

    rtlola_trace_player #(
        .DATA_W  (64),
        .DELTA_W (32),
        .DEPTH   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_delta   (rec_delta),
        .rec_value   (rec_value),
        .input_0     (input_0),
        .new_input_0 (new_input_0),
        .busy        (busy),
        .fill        (fill)
`ifdef RTLOLA_TRACE_TIMESTAMP_EN
        ,
        .ev_time     (ev_time)
`endif
    );

    always #5 clk = ~clk;

    // Reference cycle count: cleared by reset, +1 on every rising edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_cyc <= 64'd0;
        end else begin
            tb_cyc <= tb_cyc + 64'd1;
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic signed [63:0] val);
        rec_valid = v;
        rec_delta = d;
        rec_value = val;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        en  = 1'b0;
        applyStimulus(1'b0, 32'd0, 64'sd0);
        stepCycle();
        stepCycle();
        checkOutput("rst_new", 64'(new_input_0), 64'd0);
        checkOutput("rst_in0", input_0, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_fill", 64'(fill), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 64'(rec_ready), 64'd1);
        checkOutput("rel_fill", 64'(fill), 64'd0);
        $display("[TB] reset done");

        // ---------------- single record (3,7) ----------------
        en = 1'b1;
        applyStimulus(1'b1, 32'd3, 64'sd7);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        checkOutput("s1_fill", 64'(fill), 64'd1);
        checkOutput("s1_busy", 64'(busy), 64'd1);
        checkOutput("s1_new_t0", 64'(new_input_0), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            stepCycle();
            checkOutput($sformatf("s1_new_t%0d", i), 64'(new_input_0), (i == 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("s1_in0_t%0d", i), input_0, (i == 4) ? 64'd7 : 64'd0);
        end
        stepCycle();
        checkOutput("s1_idle_busy", 64'(busy), 64'd0);

        // ---------------- back-to-back (0,3),(0,4) ----------------
        applyStimulus(1'b1, 32'd0, 64'sd3);
        stepCycle();
        applyStimulus(1'b1, 32'd0, 64'sd4);
        checkOutput("b2b_pre_new", 64'(new_input_0), 64'd0);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        checkOutput("b2b_p1_new", 64'(new_input_0), 64'd1);
        checkOutput("b2b_p1_in0", input_0, 64'd3);
        stepCycle();
        checkOutput("b2b_gap_new", 64'(new_input_0), 64'd0);
        checkOutput("b2b_gap_in0", input_0, 64'd0);
        stepCycle();
        checkOutput("b2b_p2_new", 64'(new_input_0), 64'd1);
        checkOutput("b2b_p2_in0", input_0, 64'd4);
        stepCycle();
        checkOutput("b2b_post_new", 64'(new_input_0), 64'd0);
        stepCycle();
        checkOutput("b2b_idle_busy", 64'(busy), 64'd0);

        // ---------------- fill to 16 with en low ----------------
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'd100, 64'(100 + i));
            stepCycle();
        end
        applyStimulus(1'b1, 32'd100, 64'sd999);
        checkOutput("full_ready", 64'(rec_ready), 64'd0);
        checkOutput("full_fill", 64'(fill), 64'd16);
        stepCycle();
        checkOutput("full_hold_fill", 64'(fill), 64'd16);
        checkOutput("full_hold_ready", 64'(rec_ready), 64'd0);
        en = 1'b1;
        stepCycle();
        checkOutput("pop1_fill", 64'(fill), 64'd15);
        checkOutput("pop1_ready", 64'(rec_ready), 64'd1);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        checkOutput("acc17_fill", 64'(fill), 64'd16);
        checkOutput("acc17_ready", 64'(rec_ready), 64'd0);
        checkOutput("acc17_new", 64'(new_input_0), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("flush_fill", 64'(fill), 64'd0);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("flush_ready", 64'(rec_ready), 64'd1);

        // ---------------- en drop during EMIT of (2,-9) ----------------
        applyStimulus(1'b1, 32'd2, -64'sd9);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        stepCycle();
        checkOutput("en_wait1_new", 64'(new_input_0), 64'd0);
        stepCycle();
        checkOutput("en_wait2_new", 64'(new_input_0), 64'd0);
        stepCycle();
        en = 1'b0;
        #1;
        checkOutput("en_off0_new", 64'(new_input_0), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkOutput($sformatf("en_off%0d_new", i), 64'(new_input_0), 64'd0);
        end
        stepCycle();
        en = 1'b1;
        #1;
        checkOutput("en_on_new", 64'(new_input_0), 64'd1);
        checkOutput("en_on_in0", input_0, -64'sd9);
        exp_time = tb_cyc;
        stepCycle();
        checkOutput("en_after_new", 64'(new_input_0), 64'd0);
        checkOutput("en_after_in0", input_0, 64'd0);
`ifdef RTLOLA_TRACE_TIMESTAMP_EN
        checkOutput("en_ev_time", ev_time, exp_time);
`endif
        stepCycle();
        checkOutput("en_idle_new", 64'(new_input_0), 64'd0);
        checkOutput("en_idle_busy", 64'(busy), 64'd0);

        // ---------------- reset during WAIT ----------------
        applyStimulus(1'b1, 32'd50, 64'sd5);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        stepCycle();
        stepCycle();
        checkOutput("rw_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rw_busy", 64'(busy), 64'd0);
        checkOutput("rw_fill", 64'(fill), 64'd0);
        checkOutput("rw_new", 64'(new_input_0), 64'd0);
        stepCycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("rw_quiet%0d", i), 64'(new_input_0), 64'd0);
        end
        applyStimulus(1'b1, 32'd0, 64'sd11);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 64'sd0);
        checkOutput("rw_pop_new", 64'(new_input_0), 64'd0);
        stepCycle();
        checkOutput("rw_pulse_new", 64'(new_input_0), 64'd1);
        checkOutput("rw_pulse_in0", input_0, 64'd11);
        stepCycle();
        checkOutput("rw_post_new", 64'(new_input_0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
